// File: rtl/mem_io_ctrl_pkg.sv
// Shared encodings for the CPU memory/IO controller: commands, IO addresses, FSM states.
package mem_io_ctrl_pkg;

  typedef enum logic [1:0] {
    MNONE  = 2'b00,
    MREAD  = 2'b01,
    MWRITE = 2'b10,
    MILL   = 2'b11
  } mem_cmd_e;

  localparam logic [8:0] LED_ADDR = 9'h100;
  localparam logic [8:0] SW_ADDR  = 9'h140;

  // state   | meaning
  // IDLE    | waiting for a command from the CPU
  // RD_WAIT | read accepted, counting down to data capture
  // RD_DONE | read data captured, mem_ready high for one cycle
  // WR_DONE | write committed, mem_ready high for one cycle
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_DONE = 2'd2,
    WR_DONE = 2'd3
  } state_e;

  // Lower half of the address space is backed by the RAM.
  function automatic logic is_ram(input logic [8:0] a);
    return ~a[8];
  endfunction

endpackage

// File: rtl/mem_io_ctrl_ram.sv
// 256x16 single-port synchronous RAM with one-cycle registered read; contents are not reset.
module mem_io_ctrl_ram (
  input  logic        clk,
  input  logic        we,
  input  logic [7:0]  addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata
);

  logic [15:0] mem [0:255];

  // Write on we, read every cycle from the presented address (read-before-write).
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_io_ctrl.sv
// CPU memory/IO controller: RAM, write-only LED register and synchronized switch register.
module mem_io_ctrl
  import mem_io_ctrl_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mem_cmd,
  input  logic [8:0]  mem_addr,
  input  logic [15:0] write_data,
  input  logic [7:0]  sw,
  output logic [15:0] read_data,
  output logic        mem_ready,
  output logic [7:0]  led,
  output logic        err
);

  localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

  state_e      state;
  logic [8:0]  addr_q;
  logic [2:0]  cnt;
  logic [7:0]  sw_meta;
  logic [7:0]  sw_sync;
  logic [7:0]  ram_addr;
  logic [15:0] ram_rdata;
  logic        ram_we;
  logic [15:0] rd_sel;

  // Writes commit on the accept edge only while out of reset; after accept the
  // RAM keeps reading the latched address so CPU address changes are ignored.
  assign ram_we   = reset && (state == IDLE) && (mem_cmd == MWRITE) && is_ram(mem_addr);
  assign ram_addr = (state == IDLE) ? mem_addr[7:0] : addr_q[7:0];

  mem_io_ctrl_ram u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (write_data),
    .rdata (ram_rdata)
  );

  // Two-flop synchronizer for the asynchronous board switches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
    end
  end

  // Read source select from the latched address; LED and unmapped reads return zero.
  always_comb begin
    rd_sel = '0;
    if (is_ram(addr_q))       rd_sel = ram_rdata;
    else if (addr_q == SW_ADDR) rd_sel = {8'h00, sw_sync};
  end

  // Transaction FSM with registered read_data, mem_ready, led and sticky err.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      addr_q    <= '0;
      cnt       <= '0;
      read_data <= '0;
      mem_ready <= 1'b0;
      led       <= '0;
      err       <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      case (state)
        IDLE: begin
          case (mem_cmd)
            MREAD: begin
              addr_q <= mem_addr;
              cnt    <= CNT_INIT;
              state  <= RD_WAIT;
              if (!is_ram(mem_addr) && (mem_addr != SW_ADDR)) err <= 1'b1;
            end
            MWRITE: begin
              state     <= WR_DONE;
              mem_ready <= 1'b1;
              if (mem_addr == LED_ADDR) led <= write_data[7:0];
              else if (!is_ram(mem_addr)) err <= 1'b1;
            end
            MILL:    err <= 1'b1;
            default: ;
          endcase
        end
        RD_WAIT: begin
          if (cnt == 3'd0) begin
            read_data <= rd_sel;
            mem_ready <= 1'b1;
            state     <= RD_DONE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RD_DONE, WR_DONE: state <= IDLE;
        default:          state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Directed bench for mem_io_ctrl: one instance with RD_LAT=1, one with RD_LAT=4.
module tb_mem_io_ctrl;
  import mem_io_ctrl_pkg::*;

  logic        clk;
  logic        reset, reset4;
  logic [1:0]  cmd, cmd4;
  logic [8:0]  addr, addr4;
  logic [15:0] wd, wd4;
  logic [7:0]  sw;
  logic [15:0] rd, rd4;
  logic        rdy, rdy4;
  logic [7:0]  led, led4;
  logic        err, err4;

  int checks = 0;
  int passed = 0;
  int n;
  bit seen;

  mem_io_ctrl #(.RD_LAT(1)) dut (
    .clk(clk), .reset(reset), .mem_cmd(cmd), .mem_addr(addr), .write_data(wd),
    .sw(sw), .read_data(rd), .mem_ready(rdy), .led(led), .err(err)
  );

  mem_io_ctrl #(.RD_LAT(4)) dut4 (
    .clk(clk), .reset(reset4), .mem_cmd(cmd4), .mem_addr(addr4), .write_data(wd4),
    .sw(sw), .read_data(rd4), .mem_ready(rdy4), .led(led4), .err(err4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Cycles until mem_ready is seen high on the selected instance; -1 if never.
  task automatic wait_ready(input bit sel, output int cycles);
    cycles = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if ((sel ? rdy4 : rdy) === 1'b1) begin
        cycles = i;
        break;
      end
    end
  endtask

  initial begin
    reset = 1'b1; reset4 = 1'b1;
    cmd = MNONE; cmd4 = MNONE;
    addr = '0; addr4 = '0; wd = '0; wd4 = '0; sw = 8'h00;
    #2;
    reset = 1'b0; reset4 = 1'b0;
    #1;
    check("rst_read_data", 32'(rd), 32'h0);
    check("rst_mem_ready", 32'(rdy), 32'h0);
    check("rst_led", 32'(led), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    tick(); tick();
    reset = 1'b1; reset4 = 1'b1;

    // Write BEEF to RAM word 5, read it back.
    cmd = MWRITE; addr = 9'h005; wd = 16'hBEEF;
    wait_ready(0, n);
    check("wr_latency", n, 1);
    cmd = MNONE;
    tick();
    check("wr_ready_pulse", 32'(rdy), 32'h0);
    cmd = MREAD; addr = 9'h005;
    wait_ready(0, n);
    check("rd_latency", n, 2);
    check("rd_data_beef", 32'(rd), 32'hBEEF);
    cmd = MNONE;
    tick();
    check("rd_ready_pulse", 32'(rdy), 32'h0);
    check("rd_data_hold", 32'(rd), 32'hBEEF);

    // LED register write.
    cmd = MWRITE; addr = 9'h100; wd = 16'h12A5;
    wait_ready(0, n);
    check("led_wr_latency", n, 1);
    check("led_value", 32'(led), 32'hA5);
    check("led_err_clear", 32'(err), 32'h0);
    cmd = MNONE;
    tick();

    // Held read command is re-accepted after the DONE state.
    cmd = MREAD; addr = 9'h005;
    wait_ready(0, n);
    check("b2b_first", n, 2);
    wait_ready(0, n);
    check("b2b_second", n, 3);
    check("b2b_data", 32'(rd), 32'hBEEF);
    cmd = MNONE;
    tick();

    // Synchronized switch read.
    sw = 8'h3C;
    tick(); tick(); tick();
    cmd = MREAD; addr = 9'h140;
    wait_ready(0, n);
    check("sw_latency", n, 2);
    check("sw_data", 32'(rd), 32'h003C);
    cmd = MNONE;
    tick();
    check("sw_err_clear", 32'(err), 32'h0);

    // Unmapped read, then illegal command.
    cmd = MREAD; addr = 9'h1FF;
    wait_ready(0, n);
    check("unmap_latency", n, 2);
    check("unmap_data", 32'(rd), 32'h0);
    check("unmap_err", 32'(err), 32'h1);
    cmd = MNONE;
    tick();
    cmd = MILL;
    seen = 1'b0;
    repeat (3) begin
      tick();
      if (rdy === 1'b1) seen = 1'b1;
    end
    check("ill_no_ready", 32'(seen), 32'h0);
    cmd = MNONE;
    tick();
    check("err_sticky", 32'(err), 32'h1);

    // RD_LAT=4 instance.
    cmd4 = MWRITE; addr4 = 9'h033; wd4 = 16'hCAFE;
    wait_ready(1, n);
    check("l4_wr_latency", n, 1);
    cmd4 = MNONE; tick();
    cmd4 = MWRITE; addr4 = 9'h000; wd4 = 16'h1111;
    wait_ready(1, n);
    cmd4 = MNONE; tick();
    cmd4 = MWRITE; addr4 = 9'h100; wd4 = 16'h005A;
    wait_ready(1, n);
    check("l4_led", 32'(led4), 32'h5A);
    cmd4 = MNONE; tick();

    cmd4 = MREAD; addr4 = 9'h033;
    wait_ready(1, n);
    check("l4_rd_latency", n, 5);
    check("l4_rd_data", 32'(rd4), 32'hCAFE);
    check("l4_err_clear", 32'(err4), 32'h0);
    cmd4 = MNONE; tick();

    // Address changed after accept must not affect the read.
    cmd4 = MREAD; addr4 = 9'h033;
    tick();
    addr4 = 9'h000;
    wait_ready(1, n);
    check("l4_addr_change_lat", n, 4);
    check("l4_addr_change_data", 32'(rd4), 32'hCAFE);
    cmd4 = MNONE; tick();

    // Write to read-only switch register is dropped and flags err.
    cmd4 = MWRITE; addr4 = 9'h140; wd4 = 16'hFFFF;
    wait_ready(1, n);
    check("l4_sw_wr_latency", n, 1);
    check("l4_sw_wr_err", 32'(err4), 32'h1);
    cmd4 = MNONE; tick();

    // Reset one cycle before capture aborts the read.
    cmd4 = MREAD; addr4 = 9'h033;
    tick();
    addr4 = 9'h000;
    tick(); tick(); tick();
    reset4 = 1'b0;
    #1;
    check("l4_rst_read_data", 32'(rd4), 32'h0);
    check("l4_rst_ready", 32'(rdy4), 32'h0);
    check("l4_rst_led", 32'(led4), 32'h0);
    check("l4_rst_err", 32'(err4), 32'h0);
    cmd4 = MNONE;
    seen = 1'b0;
    repeat (3) begin
      tick();
      if (rdy4 === 1'b1) seen = 1'b1;
    end
    check("l4_abort_no_ready", 32'(seen), 32'h0);
    reset4 = 1'b1;
    cmd4 = MREAD; addr4 = 9'h033;
    wait_ready(1, n);
    check("l4_post_rst_latency", n, 5);
    check("l4_ram_retained", 32'(rd4), 32'hCAFE);
    cmd4 = MNONE; tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
